// File: rtl/sat_pkg.sv
// Shared types for the BCP datapath: implication record and
// the bcp control state shared by the queue stages.
package sat_pkg;

  localparam int SAT_VAR_W = 8;

  typedef struct packed {
    logic [SAT_VAR_W-1:0] var_id;
    logic                 value;
  } implication_t;

  typedef enum logic {
    RUN      = 1'b0,
    CONFLICT = 1'b1
  } bcp_state_e;

endpackage

// File: rtl/implication_match.sv
// Combinational search of queued implications for an incoming
// variable ID; queue entries are unique so at most one hits.
module implication_match
  import sat_pkg::*;
#(
  parameter int VAR_W = SAT_VAR_W,
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0][VAR_W-1:0] entry_var,
  input  logic [DEPTH-1:0]            entry_value,
  input  logic [DEPTH-1:0]            entry_valid,
  input  logic [VAR_W-1:0]            in_var,
  output logic                        hit,
  output logic                        hit_value
);

  always_comb begin
    hit       = 1'b0;
    hit_value = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_var[i] == in_var) begin
        hit       = 1'b1;
        hit_value = hit_value | entry_value[i];
      end
    end
  end

endmodule

// File: rtl/implication_queue.sv
// Implication FIFO between the unit-clause evaluator and the trail:
// drops duplicate implications and flags opposite-value conflicts.
module implication_queue
  import sat_pkg::*;
#(
  parameter int VAR_W = SAT_VAR_W,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [VAR_W-1:0] in_var,
  input  logic             in_value,
  output logic             in_ready,
  output logic             out_valid,
  output logic [VAR_W-1:0] out_var,
  output logic             out_value,
  input  logic             out_ready,
  output logic             conflict,
  output logic [VAR_W-1:0] conflict_var,
  output logic [CW-1:0]    count
);

  bcp_state_e state_q;
  bcp_state_e state_d;

  logic [DEPTH-1:0][VAR_W-1:0] mem_var;
  logic [DEPTH-1:0]            mem_value;
  logic [PW-1:0]               head;
  logic [PW-1:0]               tail;
  logic [DEPTH-1:0]            valid_mask;

  logic full;
  logic push;
  logic pop;
  logic hit;
  logic hit_value;
  logic enq;
  logic clash;

  assign full      = (count == CW'(DEPTH));
  assign in_ready  = (state_q == RUN) && !full;
  assign out_valid = (state_q == RUN) && (count != '0);
  assign out_var   = mem_var[head];
  assign out_value = mem_value[head];
  assign conflict  = (state_q == CONFLICT);

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  assign enq   = push && !hit;
  assign clash = push && hit && (hit_value != in_value);

  // Entry i is live when its distance from head is below count.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_mask[i] = CW'(PW'(PW'(i) - head)) < count;
    end
  end

  implication_match #(
    .VAR_W (VAR_W),
    .DEPTH (DEPTH)
  ) u_match (
    .entry_var   (mem_var),
    .entry_value (mem_value),
    .entry_valid (valid_mask),
    .in_var      (in_var),
    .hit         (hit),
    .hit_value   (hit_value)
  );

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      flush: state_d = RUN;
      clash: state_d = CONFLICT;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_var      <= '0;
      mem_value    <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      conflict_var <= '0;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      conflict_var <= '0;
    end else begin
      if (enq) begin
        mem_var[tail]   <= in_var;
        mem_value[tail] <= in_value;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(enq) - CW'(pop);
      if (clash) begin
        conflict_var <= in_var;
      end
    end
  end

endmodule

// File: tb/tb_implication_queue.sv
// Directed self-checking bench for implication_queue.
// Inputs change #1 after posedge; outputs are checked there too.
module tb_implication_queue;

  localparam int VAR_W = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [VAR_W-1:0] in_var;
  logic             in_value;
  logic             in_ready;
  logic             out_valid;
  logic [VAR_W-1:0] out_var;
  logic             out_value;
  logic             out_ready;
  logic             conflict;
  logic [VAR_W-1:0] conflict_var;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  implication_queue #(
    .VAR_W (VAR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_var       (in_var),
    .in_value     (in_value),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_var      (out_var),
    .out_value    (out_value),
    .out_ready    (out_ready),
    .conflict     (conflict),
    .conflict_var (conflict_var),
    .count        (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [VAR_W-1:0] v, input logic b);
    in_valid = 1'b1;
    in_var   = v;
    in_value = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_var !== '0 ||
        out_value !== 1'b0 || conflict !== 1'b0 ||
        conflict_var !== '0 || count !== '0) begin
      errors++;
      $display("FAIL %s: rdy=%b ov=%b var=%0d val=%b cf=%b cv=%0d cnt=%0d want 1 0 0 0 0 0 0",
               tag, in_ready, out_valid, out_var, out_value,
               conflict, conflict_var, count);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_var    = '0;
    in_value  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_push_pop();
    push_one(8'd5, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_var !== 8'd5 ||
        out_value !== 1'b1 || count !== 4'd1) begin
      errors++;
      $display("FAIL push5: ov=%b var=%0d val=%b cnt=%0d want 1 5 1 1",
               out_valid, out_var, out_value, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL pop5: ov=%b cnt=%0d want 0 0", out_valid, count);
    end
  endtask

  task automatic test_dedup();
    push_one(8'd12, 1'b0);
    in_valid = 1'b1;
    in_var   = 8'd12;
    in_value = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dedup_ready: in_ready=%b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd1 || conflict !== 1'b0 || out_var !== 8'd12) begin
      errors++;
      $display("FAIL dedup_count: cnt=%0d cf=%b var=%0d want 1 0 12",
               count, conflict, out_var);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dedup_drain: cnt=%0d ov=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_conflict();
    push_one(8'd7, 1'b0);
    push_one(8'd7, 1'b1);
    checks++;
    if (conflict !== 1'b1 || conflict_var !== 8'd7 || in_ready !== 1'b0 ||
        out_valid !== 1'b0 || count !== 4'd1) begin
      errors++;
      $display("FAIL conflict: cf=%b cv=%0d rdy=%b ov=%b cnt=%0d want 1 7 0 0 1",
               conflict, conflict_var, in_ready, out_valid, count);
    end
    // Entries held while in conflict, even with the consumer ready.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd1 || conflict !== 1'b1) begin
      errors++;
      $display("FAIL conflict_hold: cnt=%0d cf=%b want 1 1", count, conflict);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (conflict !== 1'b0 || conflict_var !== '0 || count !== 4'd0 ||
        in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush: cf=%b cv=%0d cnt=%0d rdy=%b ov=%b want 0 0 0 1 0",
               conflict, conflict_var, count, in_ready, out_valid);
    end
  endtask

  task automatic test_full_wrap();
    logic [VAR_W-1:0] v;
    push_one(8'd90, 1'b0);
    push_one(8'd91, 1'b1);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v = VAR_W'(20 + i);
      push_one(v, 1'(i % 2));
    end
    checks++;
    if (count !== 4'd8 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: cnt=%0d rdy=%b want 8 0", count, in_ready);
    end
    push_one(8'd99, 1'b1);
    checks++;
    if (count !== 4'd8 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL ninth: cnt=%0d cf=%b want 8 0", count, conflict);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = VAR_W'(20 + i);
      checks++;
      if (out_valid !== 1'b1 || out_var !== v || out_value !== 1'(i % 2)) begin
        errors++;
        $display("FAIL drain%0d: ov=%b var=%0d val=%b want 1 %0d %0d",
                 i, out_valid, out_var, out_value, v, i % 2);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained: cnt=%0d ov=%b want 0 0", count, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      push_one(VAR_W'(30 + i), 1'b1);
    end
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL wrap_count: cnt=%0d want 3", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = VAR_W'(30 + i);
      checks++;
      if (out_valid !== 1'b1 || out_var !== v || out_value !== 1'b1) begin
        errors++;
        $display("FAIL wrap%0d: ov=%b var=%0d val=%b want 1 %0d 1",
                 i, out_valid, out_var, out_value, v);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [VAR_W-1:0] v;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_value  = 1'b0;
    in_var    = 8'd40;
    step();
    for (int i = 1; i < 5; i++) begin
      v      = VAR_W'(40 + i);
      in_var = v;
      checks++;
      if (out_valid !== 1'b1 || out_var !== v - 8'd1 || count !== 4'd1) begin
        errors++;
        $display("FAIL stream%0d: ov=%b var=%0d cnt=%0d want 1 %0d 1",
                 i, out_valid, out_var, count, v - 8'd1);
      end
      step();
    end
    in_var = 8'd50;
    flush  = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_push: cnt=%0d ov=%b want 0 0", count, out_valid);
    end
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL flush_ghost: ov=%b var=%0d cnt=%0d want 0 - 0",
               out_valid, out_var, count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      push_one(VAR_W'(60 + i), 1'b0);
    end
    push_one(8'd62, 1'b1);
    checks++;
    if (count !== 4'd4 || conflict !== 1'b1 || conflict_var !== 8'd62) begin
      errors++;
      $display("FAIL pre_reset: cnt=%0d cf=%b cv=%0d want 4 1 62",
               count, conflict, conflict_var);
    end
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_var    = 8'd70;
    out_ready = 1'b1;
    step();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_reset_values("reset_mid");
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_dedup();
    test_conflict();
    test_full_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
